// File: rtl/updown_pkg.sv
// Shared types for the up/down counter stream monitor.
// Holds the FSM state encoding, step classes and direction codes.
`default_nettype none

package updown_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} mon_state_t;

  typedef enum logic [1:0] {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_JUMP} step_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/updown_step_classify.sv
// Combinational step classifier: compares a sample against the previous one
// modulo 2^W and reports UP, DOWN, HOLD or JUMP.
`default_nettype none

module updown_step_classify
  import updown_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] q_in,
  output step_t        step
);

  logic [W-1:0] w_diff;

  // Modular subtraction makes wrap-around (max->0, 0->max) a legal unit step.
  assign w_diff = q_in - prev;

  always_comb begin
    step = STEP_JUMP;
    if (w_diff == W'(1))
      step = STEP_UP;
    else if (w_diff == {W{1'b1}})
      step = STEP_DOWN;
    else if (w_diff == '0)
      step = STEP_HOLD;
  end

endmodule

`default_nettype wire

// File: rtl/updown_seq_monitor.sv
// Receive-side checker for an up/down counter stream: recovers direction,
// declares lock after LOCK_CNT consistent steps, flags illegal steps and reversals.
`default_nettype none

module updown_seq_monitor
  import updown_pkg::*;
#(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int RUN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [W-1:0]     q_in,
  output logic             dir,
  output logic             locked,
  output logic             err,
  output logic             rev,
  output logic [RUN_W-1:0] run_len
);

  localparam logic [3:0] LOCK_M = 4'(LOCK_CNT);

  mon_state_t       state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [3:0]       match_q, match_d;
  logic             cand_q, cand_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             rev_q, rev_d;
  logic [RUN_W-1:0] run_q, run_d;

  step_t w_step;
  logic  w_legal;
  logic  w_step_dir;

  updown_step_classify #(.W(W)) u_classify (
    .prev (prev_q),
    .q_in (q_in),
    .step (w_step)
  );

  assign w_legal    = (w_step == STEP_UP) || (w_step == STEP_DOWN);
  assign w_step_dir = (w_step == STEP_DOWN) ? DIR_DOWN : DIR_UP;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    match_d  = match_q;
    cand_d   = cand_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    rev_d    = 1'b0;
    run_d    = run_q;
    if (valid) begin
      prev_d = q_in;
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          match_d = '0;
        end
        S_ACQ: begin
          if (!w_legal) begin
            err_d   = 1'b1;
            match_d = '0;
          end else begin
            // A direction change while acquiring restarts the run without a rev pulse.
            if (match_q == '0 || w_step_dir == cand_q)
              match_d = match_q + 4'd1;
            else
              match_d = 4'd1;
            cand_d = w_step_dir;
            if (match_d == LOCK_M) begin
              state_d  = S_LOCK;
              locked_d = 1'b1;
              dir_d    = w_step_dir;
              run_d    = RUN_W'(match_d);
            end
          end
        end
        S_LOCK: begin
          if (!w_legal) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            run_d    = '0;
            state_d  = S_ACQ;
          end else if (w_step_dir == dir_q) begin
            if (run_q != {RUN_W{1'b1}})
              run_d = run_q + RUN_W'(1);
          end else begin
            dir_d  = w_step_dir;
            cand_d = w_step_dir;
            rev_d  = 1'b1;
            run_d  = RUN_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      match_q  <= '0;
      cand_q   <= DIR_UP;
      dir_q    <= DIR_UP;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      rev_q    <= 1'b0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
    end
  end

  assign dir     = dir_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign rev     = rev_q;
  assign run_len = run_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_seq_monitor.sv
// Directed self-checking bench for updown_seq_monitor (W=4, LOCK_CNT=3, RUN_W=8).
`default_nettype none

module tb_updown_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       dir, locked, err, rev;
  logic [7:0] run_len;

  int n_cmp = 0;
  int n_bad = 0;

  updown_seq_monitor #(.W(4), .LOCK_CNT(3), .RUN_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .q_in    (q_in),
    .dir     (dir),
    .locked  (locked),
    .err     (err),
    .rev     (rev),
    .run_len (run_len)
  );

  always #5 clk = ~clk;

  // Expected output bundle: {dir, locked, err, rev, run_len}
  function automatic logic [11:0] e(input logic d, input logic l, input logic er,
                                    input logic rv, input int rl);
    return {d, l, er, rv, 8'(rl)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    valid = 1'b1;
    q_in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [3:0] v);
    @(negedge clk);
    valid = 1'b0;
    q_in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dir, locked, err, rev, run_len} !== e(0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", {dir, locked, err, rev, run_len}, e(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock_up();
    logic [3:0]  v[4]   = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [11:0] x[4]   = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3)};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x[i]) begin
        n_bad++;
        $display("FAIL lock_up[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  vu[5] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    logic [11:0] xu[5] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3), e(0,1,0,0,4)};
    logic [3:0]  vd[4] = '{4'd1, 4'd0, 4'd15, 4'd14};
    logic [11:0] xd[4] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(1,1,0,0,3)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(vu[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== xu[i]) begin
        n_bad++;
        $display("FAIL wrap_up[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, xu[i]);
      end
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(vd[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== xd[i]) begin
        n_bad++;
        $display("FAIL wrap_down[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, xd[i]);
      end
    end
  endtask

  task automatic test_reversal();
    logic [3:0]  v[6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd7, 4'd6};
    logic [11:0] x[6] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3),
                          e(1,1,0,1,1), e(1,1,0,0,2)};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x[i]) begin
        n_bad++;
        $display("FAIL reversal[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x[i]);
      end
    end
  endtask

  task automatic test_jump_relock();
    logic [3:0]  v[8] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [11:0] x[8] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3),
                          e(0,0,1,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3)};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(v[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x[i]) begin
        n_bad++;
        $display("FAIL jump_relock[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x[i]);
      end
    end
  endtask

  task automatic test_hold_and_gaps();
    logic [3:0]  v[5]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};
    logic [11:0] x[5]  = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3), e(0,0,1,0,0)};
    logic [3:0]  g[3]  = '{4'd9, 4'd2, 4'd15};
    logic [3:0]  v2[3] = '{4'd5, 4'd6, 4'd7};
    logic [11:0] x2[3] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3)};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x[i]) begin
        n_bad++;
        $display("FAIL hold[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle_cycle(g[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== e(0,0,0,0,0)) begin
        n_bad++;
        $display("FAIL gap[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, e(0,0,0,0,0));
      end
    end
    // Previous sample (4) must survive the gaps, so 5,6,7 is a clean up run.
    for (int i = 0; i < 3; i++) begin
      drive(v2[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x2[i]) begin
        n_bad++;
        $display("FAIL after_gap[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x2[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0]  v[4] = '{4'd11, 4'd12, 4'd13, 4'd14};
    logic [11:0] x[4] = '{e(0,0,0,0,0), e(0,0,0,0,0), e(0,0,0,0,0), e(0,1,0,0,3)};
    do_reset();
    for (int i = 0; i < 4; i++) drive(4'(i + 7));
    n_cmp++;
    if ({dir, locked, err, rev, run_len} !== e(0,1,0,0,3)) begin
      n_bad++;
      $display("FAIL pre_async_lock: got %h expected %h", {dir, locked, err, rev, run_len}, e(0,1,0,0,3));
    end
    #2;
    valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dir, locked, err, rev, run_len} !== e(0,0,0,0,0)) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", {dir, locked, err, rev, run_len}, e(0,0,0,0,0));
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      n_cmp++;
      if ({dir, locked, err, rev, run_len} !== x[i]) begin
        n_bad++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, {dir, locked, err, rev, run_len}, x[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int          exp_run;
    logic [11:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) drive(4'(15 - i));
    exp_run = 3;
    for (int i = 0; i < 260; i++) begin
      drive(4'(12 - i - 1));
      exp_run = (exp_run < 255) ? exp_run + 1 : 255;
      got = {dir, locked, err, rev, run_len};
      n_cmp++;
      if (got !== e(1, 1, 0, 0, exp_run)) begin
        n_bad++;
        $display("FAIL saturate[%0d]: got %h expected %h", i, got, e(1, 1, 0, 0, exp_run));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_wrap();
    test_reversal();
    test_jump_relock();
    test_hold_and_gaps();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
